// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between the instruction-fetch port and the
// load/store port. One requester is granted at a time; the transfer is
// forwarded to the bus, and the bus acknowledge plus read data are returned to
// the granted port. A transfer that the bus never acknowledges is aborted and
// reported with bus_err.
//
// Handshake, requester side: a port raises x_req with stable address/control
// and holds it until it samples x_ack_n low. x_ack_n is a one-cycle active-low
// pulse, and x_rdata/bus_err are valid only during that pulse. Requests are
// sampled only in IDLE, so a request held one cycle past its ack is not served
// twice. Bus side: bus_req stays high with bus_addr/bus_write/bus_size/
// bus_wdata constant until bus_ack_n is sampled low or the timeout expires.
//
// dbg_state exposes the FSM state: 0 IDLE, 1 GNT_I, 2 GNT_D, 3 RESP.
module mem_bus_arbiter #(
    parameter int BIT_WIDTH = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req,
    input  logic [BIT_WIDTH-1:0] i_addr,
    output logic [BIT_WIDTH-1:0] i_rdata,
    output logic                 i_ack_n,
    input  logic                 d_req,
    input  logic                 d_write,
    input  logic [1:0]           d_size,
    input  logic [BIT_WIDTH-1:0] d_addr,
    input  logic [BIT_WIDTH-1:0] d_wdata,
    output logic [BIT_WIDTH-1:0] d_rdata,
    output logic                 d_ack_n,
    output logic                 bus_err,
    output logic                 bus_req,
    output logic                 bus_write,
    output logic [1:0]           bus_size,
    output logic [BIT_WIDTH-1:0] bus_addr,
    output logic [BIT_WIDTH-1:0] bus_wdata,
    input  logic [BIT_WIDTH-1:0] bus_rdata,
    input  logic                 bus_ack_n,
    output logic [1:0]           dbg_state
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
    localparam logic        GRANT_I     = 1'b0;
    localparam logic        GRANT_D     = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [15:0]            cnt_q, cnt_d, cnt_inc;
    logic                   last_q, last_d;
    logic                   bus_req_d, bus_write_d, bus_err_d;
    logic [1:0]             bus_size_d;
    logic [BIT_WIDTH-1:0]   bus_addr_d, bus_wdata_d;
    logic [BIT_WIDTH-1:0]   i_rdata_d, d_rdata_d;
    logic                   i_ack_n_d, d_ack_n_d;
    logic                   xfer_done;

    assign dbg_state = state_q;

    // Next-state and next-output logic; every register holds unless a state says otherwise.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        bus_req_d   = bus_req;
        bus_write_d = bus_write;
        bus_size_d  = bus_size;
        bus_addr_d  = bus_addr;
        bus_wdata_d = bus_wdata;
        i_rdata_d   = i_rdata;
        d_rdata_d   = d_rdata;
        i_ack_n_d   = 1'b1;
        d_ack_n_d   = 1'b1;
        bus_err_d   = 1'b0;
        cnt_inc     = cnt_q + 16'd1;
        xfer_done   = !bus_ack_n || (cnt_inc == TIMEOUT_CNT);

        case (state_q)
            ST_IDLE: begin
                // Under contention the port that did not go last wins.
                if (d_req && (!i_req || last_q == GRANT_I)) begin
                    state_d     = ST_GNT_D;
                    bus_req_d   = 1'b1;
                    bus_write_d = d_write;
                    bus_size_d  = d_size;
                    bus_addr_d  = d_addr;
                    bus_wdata_d = d_wdata;
                    cnt_d       = '0;
                end else if (i_req) begin
                    state_d     = ST_GNT_I;
                    bus_req_d   = 1'b1;
                    bus_write_d = 1'b0;
                    bus_size_d  = 2'b00;
                    bus_addr_d  = i_addr;
                    bus_wdata_d = '0;
                    cnt_d       = '0;
                end
            end
            ST_GNT_I, ST_GNT_D: begin
                if (xfer_done) begin
                    // A timed-out transfer still counts as this port's turn,
                    // so a dead address cannot starve the other port.
                    state_d   = ST_RESP;
                    bus_req_d = 1'b0;
                    cnt_d     = '0;
                    bus_err_d = bus_ack_n;
                    if (state_q == ST_GNT_D) begin
                        last_d    = GRANT_D;
                        d_ack_n_d = 1'b0;
                        d_rdata_d = bus_ack_n ? '0 : bus_rdata;
                    end else begin
                        last_d    = GRANT_I;
                        i_ack_n_d = 1'b0;
                        i_rdata_d = bus_ack_n ? '0 : bus_rdata;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and all registered outputs; reset drops any transfer in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            last_q    <= GRANT_I;
            bus_req   <= 1'b0;
            bus_write <= 1'b0;
            bus_size  <= 2'b00;
            bus_addr  <= '0;
            bus_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ack_n   <= 1'b1;
            d_ack_n   <= 1'b1;
            bus_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            bus_req   <= bus_req_d;
            bus_write <= bus_write_d;
            bus_size  <= bus_size_d;
            bus_addr  <= bus_addr_d;
            bus_wdata <= bus_wdata_d;
            i_rdata   <= i_rdata_d;
            d_rdata   <= d_rdata_d;
            i_ack_n   <= i_ack_n_d;
            d_ack_n   <= d_ack_n_d;
            bus_err   <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: reset checks, a vector table of single and
// contended transfers, hand sequences for reset-in-flight, spurious bus
// acknowledge and sustained contention, then randomized traffic checked by a
// transaction-level model (alternating grant, ack-or-timeout outcome).
module tb_mem_bus_arbiter;

  localparam int W     = 32;
  localparam int TO    = 4;
  localparam int EXP_W = W + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_req = 1'b0;
  logic [W-1:0] i_addr = '0;
  logic [W-1:0] i_rdata;
  logic         i_ack_n;
  logic         d_req = 1'b0;
  logic         d_write = 1'b0;
  logic [1:0]   d_size = 2'b00;
  logic [W-1:0] d_addr = '0;
  logic [W-1:0] d_wdata = '0;
  logic [W-1:0] d_rdata;
  logic         d_ack_n;
  logic         bus_err;
  logic         bus_req;
  logic         bus_write;
  logic [1:0]   bus_size;
  logic [W-1:0] bus_addr;
  logic [W-1:0] bus_wdata;
  logic [W-1:0] bus_rdata = '0;
  logic         bus_ack_n = 1'b1;
  logic [1:0]   dbg_state;

  mem_bus_arbiter #(.BIT_WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack_n(i_ack_n),
    .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack_n(d_ack_n),
    .bus_err(bus_err), .bus_req(bus_req), .bus_write(bus_write),
    .bus_size(bus_size), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack_n(bus_ack_n), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];   // {port(1=D), err, rdata}
  logic lg_m = 1'b0;            // model: last granted port, 0 = I, 1 = D
  int mem_wait = 0;             // cycles of bus_req before memory acks
  bit spurious = 1'b0;
  int mem_cnt = 0;
  bit ack_i_seen = 1'b0;
  bit ack_d_seen = 1'b0;
  bit prev_ack_i = 1'b0;
  bit prev_ack_d = 1'b0;
  int ack_total = 0;

  function automatic logic [W-1:0] mem_fn(input logic [W-1:0] a);
    return a ^ 32'h0000_0503;
  endfunction

  // ---------------- memory model ----------------
  always @(negedge clk) begin
    if (bus_req) begin
      bus_ack_n = (mem_cnt >= mem_wait) ? 1'b0 : 1'b1;
      mem_cnt = mem_cnt + 1;
    end else begin
      bus_ack_n = !spurious;
      mem_cnt = 0;
    end
    bus_rdata = mem_fn(bus_addr);
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outcome of one transfer; the model also advances its turn tracker.
  task automatic push_exp(input logic port, input logic err, input logic [W-1:0] addr);
    logic [W-1:0] rd;
    rd = err ? '0 : mem_fn(addr);
    exp_q.push_back({port, err, rd});
    lg_m = port;
  endtask

  // One cycle: advance to the negedge and score any acknowledge seen there.
  task automatic tick();
    logic [EXP_W-1:0] e;
    @(negedge clk);
    ack_i_seen = !i_ack_n;
    ack_d_seen = !d_ack_n;
    if (ack_i_seen || ack_d_seen) begin
      ack_total++;
      check("ack_one_port", ack_i_seen & ack_d_seen, 0);
      check("ack_pulse_len", (ack_i_seen & prev_ack_i) | (ack_d_seen & prev_ack_d), 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: i_ack_n=%b d_ack_n=%b expected none (t=%0t)",
                 i_ack_n, d_ack_n, $time);
      end else begin
        e = exp_q.pop_front();
        check("ack_port", ack_d_seen, e[W+1]);
        check("ack_err", bus_err, e[W]);
        check("ack_rdata", ack_d_seen ? d_rdata : i_rdata, e[W-1:0]);
      end
    end
    prev_ack_i = ack_i_seen;
    prev_ack_d = ack_d_seen;
  endtask

  // ---------------- driver ----------------
  // Presents requests on one or both ports, retires each on its ack, and
  // checks bus fields and grant duration for each transfer.
  task automatic run_txn(input logic ui, input logic ud, input logic dw, input logic [1:0] ds,
                         input logic [W-1:0] ia, input logic [W-1:0] da,
                         input logic [W-1:0] dwd, input int w,
                         output int lat, output logic [W-1:0] f_rdata, output logic f_err);
    logic ord[2];
    int n, idx, gcnt, exp_gnt;
    bit bus_ok, err;
    err = (w + 1 > TO);
    exp_gnt = err ? TO : w + 1;
    if (ui && ud) begin
      ord[0] = (lg_m == 1'b0);
      ord[1] = ~ord[0];
      n = 2;
    end else begin
      ord[0] = ud;
      ord[1] = 1'b0;
      n = 1;
    end
    for (int k = 0; k < n; k++) push_exp(ord[k], err, ord[k] ? da : ia);
    mem_wait = w;
    i_addr = ia; d_write = dw; d_size = ds; d_addr = da; d_wdata = dwd;
    i_req = ui; d_req = ud;
    idx = 0; gcnt = 0; bus_ok = 1'b1; lat = -1; f_rdata = 'x; f_err = 1'bx;
    for (int cyc = 0; cyc < 64 && idx < n; cyc++) begin
      tick();
      if (bus_req) begin
        gcnt++;
        if (ord[idx])
          bus_ok &= (bus_addr == da && bus_write == dw && bus_size == ds && bus_wdata == dwd);
        else
          bus_ok &= (bus_addr == ia && bus_write == 1'b0 && bus_size == 2'b00);
      end
      if (ord[idx] ? ack_d_seen : ack_i_seen) begin
        if (idx == 0) begin
          lat = cyc + 1;
          f_rdata = ord[0] ? d_rdata : i_rdata;
          f_err = bus_err;
        end
        check("gnt_cycles", gcnt, exp_gnt);
        gcnt = 0;
        if (ord[idx]) d_req = 1'b0; else i_req = 1'b0;
        idx++;
      end
    end
    check("txn_done", idx, n);
    check("bus_fields", bus_ok, 1);
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         ui, ud, dw;
    logic [1:0]   ds;
    logic [W-1:0] ia, da, dwd;
    int           w;
    int           exp_lat;
    logic [W-1:0] exp_rdata;
    logic         exp_err;
  } vec_t;

  vec_t vecs[8];

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, n0, acks;
    logic [W-1:0] f_rdata;
    logic f_err;
    bit idle_ok;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0010, 32'h0, 32'h0, 0, 2, 32'h0000_0513, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 2'b10, 32'h0, 32'hF000_0000, 32'h0000_0041, 1, 3, 32'hF000_0503, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 2'b01, 32'h0, 32'h0800_0004, 32'h0, 2, 4, 32'h0800_0507, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 2'b00, 32'h0000_0020, 32'h1000_0000, 32'h0, 0, 2, 32'h0000_0523, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 2'b11, 32'h0000_0024, 32'h2000_0008, 32'hDEAD_BEEF, 3, 5, 32'h0000_0527, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h3000_0000, 32'h0, 99, 5, 32'h0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0030, 32'h0, 32'h0, 4, 5, 32'h0, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 2'b00, 32'h0000_0040, 32'h0000_0050, 32'h0, 0, 2, 32'h0000_0553, 1'b0};

    // Reset values
    #1 rst = 1'b0;
    tick();
    tick();
    check("rst_ctrl", {bus_req, bus_write, bus_err, bus_size, i_ack_n, d_ack_n, dbg_state},
          9'b0_0_0_00_1_1_00);
    check("rst_bus_data", {bus_addr, bus_wdata}, 64'h0);
    check("rst_rdata", {i_rdata, d_rdata}, 64'h0);
    rst = 1'b1;
    lg_m = 1'b0;
    tick();

    // Reset while a load is in flight: bus drops at once, no ack afterwards
    d_req = 1'b1; d_addr = 32'h0800_0000; d_write = 1'b0; d_size = 2'b00; mem_wait = 99;
    tick(); tick(); tick();
    check("gnt_d_active", {bus_req, dbg_state}, {1'b1, 2'd2});
    #2 rst = 1'b0;
    #1;
    check("rst_mid_gnt", {bus_req, d_ack_n, i_ack_n, dbg_state}, {1'b0, 1'b1, 1'b1, 2'd0});
    d_req = 1'b0;
    exp_q.delete();
    lg_m = 1'b0;
    n0 = ack_total;
    tick();
    rst = 1'b1;
    repeat (10) tick();
    check("no_ack_after_reset", ack_total - n0, 0);

    // Table-driven transfers
    for (int v = 0; v < 8; v++) begin
      run_txn(vecs[v].ui, vecs[v].ud, vecs[v].dw, vecs[v].ds, vecs[v].ia, vecs[v].da,
              vecs[v].dwd, vecs[v].w, lat, f_rdata, f_err);
      check($sformatf("vec%0d_lat", v), lat, vecs[v].exp_lat);
      check($sformatf("vec%0d_rdata", v), f_rdata, vecs[v].exp_rdata);
      check($sformatf("vec%0d_err", v), f_err, vecs[v].exp_err);
    end

    // Spurious bus acknowledge while idle
    n0 = ack_total;
    idle_ok = 1'b1;
    spurious = 1'b1;
    repeat (6) begin
      tick();
      idle_ok &= (dbg_state == 2'd0) && !bus_req;
    end
    spurious = 1'b0;
    tick();
    check("spurious_idle", idle_ok, 1);
    check("spurious_no_ack", ack_total - n0, 0);

    // Sustained contention from reset: D, I, D, I, ...
    rst = 1'b0;
    exp_q.delete();
    lg_m = 1'b0;
    i_addr = 32'h0000_0010; d_addr = 32'h0800_0004; d_write = 1'b0; d_size = 2'b00;
    mem_wait = 0;
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 6; k++) push_exp((k % 2) == 0, 1'b0, (k % 2) == 0 ? d_addr : i_addr);
    tick();
    rst = 1'b1;
    n0 = ack_total;
    for (int cyc = 0; cyc < 80 && (ack_total - n0) < 6; cyc++) tick();
    i_req = 1'b0; d_req = 1'b0;
    acks = ack_total - n0;
    check("contention_acks", acks, 6);
    repeat (4) tick();
    check("contention_no_extra", ack_total - n0, 6);
    check("contention_q_empty", exp_q.size(), 0);

    // Randomized traffic against the transaction model
    for (int r = 0; r < 40; r++) begin
      int mode, w;
      logic ui, ud;
      mode = $urandom_range(0, 2);
      ui = (mode != 1);
      ud = (mode != 0);
      w = $urandom_range(0, 5);
      run_txn(ui, ud, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              $urandom, $urandom, $urandom, w, lat, f_rdata, f_err);
      check("rand_lat", lat, ((w + 1 > TO) ? TO : w + 1) + 1);
    end
    check("final_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
